clock_set_ctrl: RTL
===================

# clock_set_ctrl

Time-setting controller for the 7-segment clock. It takes the debounced `fast_set`, `set_hours` and `set_minutes` buttons and the `clk_gen` set strobes, and issues single-cycle increment strobes to the hours and minutes counters. Behaviour is one step per press, then auto-repeat after a hold delay. Only one button owns the set path at a time. The block sits between `button_debounce`/`clk_gen` and the timekeeping core.

## Interface
- `HOLD_DELAY`, default 4: slow-set strobes a button must be held after the first step before auto-repeat begins (range 1–7).
- `i_clk` in 1: system clock; the only clock in the block.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_slow_set_stb` in 1: single-cycle slow repeat strobe from `clk_gen`.
- `i_fast_set_stb` in 1: single-cycle fast repeat strobe from `clk_gen`.
- `i_fast_set_db` in 1: debounced fast-set select level.
- `i_set_hours_db` in 1: debounced hours button level.
- `i_set_minutes_db` in 1: debounced minutes button level.
- `o_inc_hours_stb` out 1: one-cycle hours increment.
- `o_inc_minutes_stb` out 1: one-cycle minutes increment.
- `o_set_active` out 1: high while a button owns the set path; the timekeeper holds seconds at 0 while this is high.

## Operation
- **States:** IDLE, DELAY, REPEAT, WAIT_RELEASE. A 1-bit `owner` register records the active button (0 = hours, 1 = minutes).
- **IDLE:**
  - A rising edge on a button (current 1, previous registered sample 0) sets `owner`.
  - The block pulses that button's increment output once and enters DELAY with the delay counter cleared.
  - If both buttons rise in the same cycle, hours wins.
- **DELAY:**
  - The counter increments on each `i_slow_set_stb`.
  - When the counter reaches `HOLD_DELAY`, the block enters REPEAT.
  - No increments are issued in DELAY.
- **REPEAT:**
  - The repeat strobe is `i_fast_set_stb` when `i_fast_set_db` = 1, otherwise `i_slow_set_stb`.
  - Each repeat strobe pulses the owner's increment output.
  - `i_fast_set_db` is sampled every cycle, so a change takes effect on the next strobe.
- **Release:**
  - In DELAY or REPEAT, owner button = 0 sends the block to WAIT_RELEASE, with no increment in that cycle.
  - If the non-owner button is still high, the block stays in WAIT_RELEASE.
- **WAIT_RELEASE:**
  - The block returns to IDLE when both buttons are 0.
  - Presses of the non-owner button during ownership are ignored. A new step requires a full release of both buttons followed by a fresh rising edge.
- **`o_set_active`:** 1 in DELAY and REPEAT, 0 in IDLE and WAIT_RELEASE.
- **Counter:** 3-bit, saturating at `HOLD_DELAY`; never wraps.

## Timing
- **Reset:**
  - While `i_reset` is high: all outputs 0, state IDLE, counter 0, edge registers 0.
  - On reset release, edge registers load the current button levels. A button already held at release therefore produces no edge and must be released first.
- **Reset mid-operation:** state, counter and outputs clear asynchronously. Any strobe in flight is dropped.
- **Press latency:**
  - The debounced input rises in cycle N.
  - The increment strobe is high in cycle N+1 (registered output), for exactly one cycle.
  - `o_set_active` rises in cycle N+1.
- **First repeat:** the strobe appears 1 cycle after the `i_slow_set_stb`/`i_fast_set_stb` pulse that follows DELAY→REPEAT. The strobe that completes DELAY does not itself increment.
- **Release latency:**
  - Owner falls in cycle N; `o_set_active` falls in cycle N+1.
  - A repeat strobe coincident with release in cycle N produces no increment.
- **Increment spacing:** increments are never issued in consecutive cycles unless the input strobes are consecutive. `o_inc_hours_stb` and `o_inc_minutes_stb` are never high together.

## Structure
- **Shared package `clock_set_pkg`:**
  - state encoding: IDLE = 0, DELAY = 1, REPEAT = 2, WAIT_RELEASE = 3
  - owner encoding
  - counter width constant (3)
- **Sub-module `button_edge`:** one instance per button. It holds the previous-sample register with reset-release preload and outputs the registered level and a rise pulse.
- The FSM, counter and output registers live in `clock_set_ctrl`.
- Shares the `clk_gen` strobes with the debouncer; no second clock.

## Test plan
- **Single tap:** hours rise, held 3 slow strobes, release → exactly one `o_inc_hours_stb` 1 cycle after the rise. `o_set_active` high 1 cycle after the rise through the release cycle, falling 1 cycle after release.
- **Slow auto-repeat:** minutes held for `HOLD_DELAY`+5 = 9 slow strobes, fast = 0 → 1 + 5 = 6 `o_inc_minutes_stb` pulses, each 1 cycle after its strobe.
- **Fast switch:** hours held in REPEAT, `i_fast_set_db` raised → increments then track `i_fast_set_stb`. Lowering it returns to slow-strobe pacing from the next strobe.
- **Simultaneous/contention:**
  - Both buttons rise in the same cycle → only hours steps.
  - Minutes pressed while hours owns the path → ignored.
  - Release hours, keep minutes → WAIT_RELEASE with zero increments until both are released.
- **Reset cases:**
  - Reset asserted mid-REPEAT → outputs 0 immediately.
  - Button held through reset release → no increment until release and re-press.
  - Re-press → one step 1 cycle after the rise.

Source files
------------

// File: rtl/clock_set_pkg.sv
// Shared types and constants for the clock time-setting controller.
package clock_set_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DELAY        = 2'd1,
    REPEAT       = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam logic OWNER_HOURS   = 1'b0;
  localparam logic OWNER_MINUTES = 1'b1;

  localparam int CNT_W = 3;

endpackage

// File: rtl/clock_set_ctrl_button_edge.sv
// Rising-edge detector for one debounced button.
// A held button is ignored until it has been released after reset.
module button_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic prev_level,
  output logic rise
);

  logic prev_reg;
  logic armed_reg;

  // armed_reg masks the first cycle after reset, so prev_reg preloads the live level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg  <= 1'b0;
      armed_reg <= 1'b0;
    end else begin
      prev_reg  <= level;
      armed_reg <= 1'b1;
    end
  end

  assign prev_level = prev_reg;
  assign rise       = armed_reg & level & ~prev_reg;

endmodule

// File: rtl/clock_set_ctrl.sv
// Hours/minutes set controller: one step per press, auto-repeat after a hold delay,
// with a single button owning the set path until both buttons are released.
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int HOLD_DELAY = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_slow_set_stb,
  input  logic i_fast_set_stb,
  input  logic i_fast_set_db,
  input  logic i_set_hours_db,
  input  logic i_set_minutes_db,
  output logic o_inc_hours_stb,
  output logic o_inc_minutes_stb,
  output logic o_set_active
);

  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_DELAY);

  logic [1:0] btn_level;
  logic [1:0] btn_rise;
  logic [1:0] btn_prev_unused;

  assign btn_level = {i_set_minutes_db, i_set_hours_db};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      button_edge u_edge (
        .clk        (i_clk),
        .rst        (i_reset),
        .level      (btn_level[gi]),
        .prev_level (btn_prev_unused[gi]),
        .rise       (btn_rise[gi])
      );
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             owner_reg, owner_next;
  logic             inc_hours_reg, inc_hours_next;
  logic             inc_minutes_reg, inc_minutes_next;

  logic owner_level;
  logic repeat_stb;

  assign owner_level = (owner_reg == OWNER_MINUTES) ? i_set_minutes_db : i_set_hours_db;
  assign repeat_stb  = i_fast_set_db ? i_fast_set_stb : i_slow_set_stb;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      owner_reg       <= OWNER_HOURS;
      inc_hours_reg   <= 1'b0;
      inc_minutes_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      owner_reg       <= owner_next;
      inc_hours_reg   <= inc_hours_next;
      inc_minutes_reg <= inc_minutes_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    owner_next       = owner_reg;
    inc_hours_next   = 1'b0;
    inc_minutes_next = 1'b0;

    case (state_reg)
      IDLE: begin
        // Hours is checked first so it wins a simultaneous press.
        if (btn_rise[0]) begin
          owner_next     = OWNER_HOURS;
          inc_hours_next = 1'b1;
          cnt_next       = '0;
          state_next     = DELAY;
        end else if (btn_rise[1]) begin
          owner_next       = OWNER_MINUTES;
          inc_minutes_next = 1'b1;
          cnt_next         = '0;
          state_next       = DELAY;
        end
      end

      DELAY: begin
        if (!owner_level) begin
          state_next = WAIT_RELEASE;
        end else if (i_slow_set_stb) begin
          if (cnt_reg != HOLD_CNT) begin
            cnt_next = cnt_reg + 3'd1;
          end
          if (cnt_next == HOLD_CNT) begin
            state_next = REPEAT;
          end
        end
      end

      REPEAT: begin
        if (!owner_level) begin
          state_next = WAIT_RELEASE;
        end else if (repeat_stb) begin
          if (owner_reg == OWNER_MINUTES) begin
            inc_minutes_next = 1'b1;
          end else begin
            inc_hours_next = 1'b1;
          end
        end
      end

      WAIT_RELEASE: begin
        if (!i_set_hours_db && !i_set_minutes_db) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_inc_hours_stb   = inc_hours_reg;
  assign o_inc_minutes_stb = inc_minutes_reg;
  assign o_set_active      = (state_reg == DELAY) || (state_reg == REPEAT);

endmodule
